// File: rtl/tl_ul_mem_slave_pkg.sv
// Shared widths, TileLink-UL opcodes and payload types for the TL-UL memory slave.
package tl_ul_mem_slave_pkg;

    localparam int unsigned TL_ADDR_W = 32;
    localparam int unsigned TL_DATA_W = 32;
    localparam int unsigned TL_SRC_W  = 4;
    localparam int unsigned TL_SIZE_W = 2;
    localparam int unsigned TL_BYTES  = TL_DATA_W / 8;
    localparam int unsigned TL_LANE_W = $clog2(TL_BYTES);
    localparam int unsigned TL_LSB_W  = (TL_LANE_W > 0) ? TL_LANE_W : 1;

    localparam logic [2:0] TL_A_OPCODE_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_OPCODE_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_OPCODE_GET         = 3'd4;

    localparam logic [2:0] TL_CHANNEL_D_OPCODE_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_CHANNEL_D_OPCODE_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [TL_SIZE_W-1:0] size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_DATA_W-1:0] data;
        logic                 error;
    } tl_ul_rsp_t;

    // Request context carried alongside the memory read latency
    typedef struct packed {
        logic                 valid;
        logic [2:0]           opcode;
        logic [TL_SIZE_W-1:0] size;
        logic [TL_SRC_W-1:0]  source;
        logic [TL_BYTES-1:0]  mask;
        logic                 error;
    } tl_ul_pipe_t;

    function automatic logic [TL_BYTES-1:0] tl_lane_mask(
        input logic [TL_SIZE_W-1:0] size,
        input logic [TL_LSB_W-1:0]  addr_lsbs
    );
        logic [TL_BYTES-1:0] m;
        int unsigned lo;
        int unsigned hi;
        lo = 32'(addr_lsbs);
        hi = lo + (32'd1 << size);
        for (int unsigned i = 0; i < TL_BYTES; i++) begin
            m[i] = (i >= lo) && (i < hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/tl_ul_mem_slave_fifo.sv
// Synchronous response FIFO with wrap-bit pointers to tell full from empty.
module tl_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wen;
    logic             ren;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign wen   = push && (!full || pop);
    assign ren   = pop && !empty;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wen) wptr <= wptr + (AW+1)'(1);
            if (ren) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wen) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tl_ul_mem_slave.sv
// TileLink-UL slave in front of a fixed-latency single-port RAM; in-order, credit-limited.
module tl_ul_mem_slave
    import tl_ul_mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_W     = TL_ADDR_W,
    parameter int unsigned DATA_W     = TL_DATA_W,
    parameter int unsigned SRC_W      = TL_SRC_W,
    parameter int unsigned SIZE_W     = TL_SIZE_W,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_opcode,
    input  logic [2:0]            a_param,
    input  logic [SIZE_W-1:0]     a_size,
    input  logic [SRC_W-1:0]      a_source,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_mask,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_opcode,
    output logic [1:0]            d_param,
    output logic [SIZE_W-1:0]     d_size,
    output logic [SRC_W-1:0]      d_source,
    output logic [DATA_W-1:0]     d_data,
    output logic                  d_error,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned FIFO_W = $bits(tl_ul_rsp_t);

    logic                accept;
    logic                legal;
    logic                aligned;
    logic [TL_BYTES-1:0] covered;
    logic [CNT_W-1:0]    out_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                rsp_push;
    logic                rsp_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W-1:0]   lanes;
    tl_ul_pipe_t         pipe_in;
    tl_ul_pipe_t         pipe_out;
    tl_ul_pipe_t         pipe [RD_LATENCY];
    tl_ul_rsp_t          rsp_in;
    tl_ul_rsp_t          rsp_head;
    logic                unused;

    assign unused = ^{a_param, fifo_count, fifo_full};

    // Request legality, evaluated on the live channel A payload
    always_comb begin
        covered = tl_lane_mask(a_size, a_address[TL_LSB_W-1:0]);
        aligned = 1'b1;
        for (int i = 0; i < int'(TL_LANE_W); i++) begin
            if ((i < int'(a_size)) && a_address[i]) aligned = 1'b0;
        end
        legal = (32'(a_size) <= TL_LANE_W) && aligned && (a_mask != '0)
                && ((a_mask & ~covered) == '0);
        case (a_opcode)
            TL_A_OPCODE_GET,
            TL_A_OPCODE_PUT_FULL:    legal = legal && (a_mask == covered);
            TL_A_OPCODE_PUT_PARTIAL: legal = legal;
            default:                 legal = 1'b0;
        endcase
    end

    assign accept    = a_valid && a_ready;
    assign mem_en    = accept && legal;
    assign mem_we    = mem_en && (a_opcode != TL_A_OPCODE_GET);
    assign mem_addr  = mem_en ? {a_address[ADDR_W-1:TL_LANE_W], TL_LANE_W'(0)} : '0;
    assign mem_wdata = mem_en ? a_data : '0;
    assign mem_wstrb = mem_we ? a_mask : '0;

    always_comb begin
        pipe_in        = '0;
        pipe_in.valid  = accept;
        pipe_in.opcode = a_opcode;
        pipe_in.size   = a_size;
        pipe_in.source = a_source;
        pipe_in.mask   = a_mask;
        pipe_in.error  = !legal;
    end

    // Every accepted request rides the pipe so reads and writes stay ordered
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= pipe_in;
            for (int i = 1; i < int'(RD_LATENCY); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign pipe_out = pipe[RD_LATENCY-1];
    assign rsp_push = pipe_out.valid;

    always_comb begin
        lanes = '0;
        for (int b = 0; b < int'(TL_BYTES); b++) lanes[b*8 +: 8] = {8{pipe_out.mask[b]}};
        rsp_in        = '0;
        rsp_in.opcode = (pipe_out.opcode == TL_A_OPCODE_GET) ?
                        TL_CHANNEL_D_OPCODE_ACCESS_ACK_DATA : TL_CHANNEL_D_OPCODE_ACCESS_ACK;
        rsp_in.size   = pipe_out.size;
        rsp_in.source = pipe_out.source;
        rsp_in.error  = pipe_out.error;
        rsp_in.data   = ((pipe_out.opcode == TL_A_OPCODE_GET) && !pipe_out.error) ?
                        (mem_rdata & lanes) : '0;
    end

    tl_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (rsp_push),
        .wdata   (rsp_in),
        .pop     (rsp_pop),
        .rdata   (rsp_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign d_valid  = !fifo_empty;
    assign rsp_pop  = d_valid && d_ready;
    assign d_opcode = d_valid ? rsp_head.opcode : '0;
    assign d_param  = '0;
    assign d_size   = d_valid ? rsp_head.size   : '0;
    assign d_source = d_valid ? rsp_head.source : '0;
    assign d_data   = d_valid ? rsp_head.data   : '0;
    assign d_error  = d_valid && rsp_head.error;

    // Credits cover pipe plus FIFO; a_ready comes straight from a flop
    always_comb begin
        cnt_next = out_cnt;
        if (accept)  cnt_next = cnt_next + CNT_W'(1);
        if (rsp_pop) cnt_next = cnt_next - CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_cnt <= '0;
            a_ready <= 1'b0;
        end else begin
            out_cnt <= cnt_next;
            a_ready <= (cnt_next < CNT_W'(RSP_DEPTH));
        end
    end

endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Directed bench for tl_ul_mem_slave with a response scoreboard and a behavioural RAM.
module tb_tl_ul_mem_slave;

    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_PUTP = 3'd1;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [3:0]  src;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nresp = 0;
    exp_t        exp_q[$];
    int          resp_cyc[$];
    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_src;
    logic [31:0] prev_data;
    logic [31:0] ram [256];
    logic [31:0] shadow [256];
    bit          ram_loaded = 1'b0;

    tl_ul_mem_slave dut (
        .clk_i(clk), .reset_i(reset_i),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_error(d_error),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h0;
        return {8'(i), 8'h5A, 8'(255 - i), 8'(i * 7)};
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic bit is_legal(input logic [2:0] op, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [3:0] mask);
        int nb;
        logic [3:0] cov;
        if (size > 2'd2) return 1'b0;
        nb = 1 << size;
        if ((addr % nb) != 0) return 1'b0;
        cov = 4'((1 << nb) - 1) << addr[1:0];
        if (mask == 4'h0) return 1'b0;
        if ((mask & ~cov) != 4'h0) return 1'b0;
        if (op == OP_GET || op == OP_PUTF) return mask == cov;
        return op == OP_PUTP;
    endfunction

    // Behavioural single-port RAM, RD_LATENCY = 1
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Response monitor: handshake seen at negedge completes at the next posedge
    always @(negedge clk) begin
        if (!reset_i) begin
            chk("fifo_overflow", 64'(dut.fifo_full && dut.rsp_push && !dut.rsp_pop), 64'd0);
            if (d_valid && prev_stall) begin
                chk("hold_source", 64'(d_source), 64'(prev_src));
                chk("hold_data", 64'(d_data), 64'(prev_data));
            end
            if (d_valid && d_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(d_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("d_opcode", 64'(d_opcode), 64'(mon_e.op));
                    chk("d_size", 64'(d_size), 64'(mon_e.size));
                    chk("d_source", 64'(d_source), 64'(mon_e.src));
                    chk("d_data", 64'(d_data), 64'(mon_e.data));
                    chk("d_error", 64'(d_error), 64'(mon_e.err));
                    chk("d_param", 64'(d_param), 64'd0);
                    nresp++;
                    resp_cyc.push_back(cyc);
                end
            end
            prev_stall = d_valid && !d_ready;
            prev_src   = d_source;
            prev_data  = d_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [3:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input int budget, output bit ok, output int waited);
        bit   legal;
        exp_t e;
        a_opcode = op; a_size = size; a_source = src; a_address = addr;
        a_mask = mask; a_data = data; a_valid = 1'b1;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            if (a_ready) ok = 1'b1;
            else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (ok) begin
            legal  = is_legal(op, size, addr, mask);
            e.op   = (op == OP_GET) ? 3'd1 : 3'd0;
            e.size = size;
            e.src  = src;
            e.err  = !legal;
            e.data = (op == OP_GET && legal) ? (shadow[addr[9:2]] & expand(mask)) : 32'h0;
            chk("mem_en", 64'(mem_en), 64'(legal));
            if (legal) begin
                chk("mem_we", 64'(mem_we), 64'(op != OP_GET));
                chk("mem_wstrb", 64'(mem_wstrb), 64'((op == OP_GET) ? 4'h0 : mask));
                chk("mem_addr", 64'(mem_addr), 64'({addr[31:2], 2'b00}));
                if (op != OP_GET) begin
                    chk("mem_wdata", 64'(mem_wdata), 64'(data));
                    for (int b = 0; b < 4; b++)
                        if (mask[b]) shadow[addr[9:2]][b*8 +: 8] = data[b*8 +: 8];
                end
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int w;
        int acc;
        int n0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        reset_i = 1'b1; d_ready = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0;
        a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_d_data", 64'(d_data), 64'd0);
        reset_i = 1'b0;

        // Single Get with latency check
        send(OP_GET, 2'd2, 4'd3, 32'h10, 4'hF, 32'h0, 5, ok, w);
        chk("get1_acc", 64'(ok), 64'd1);
        @(negedge clk);
        chk("get1_early", 64'(d_valid), 64'd0);
        @(negedge clk);
        chk("get1_ontime", 64'(d_valid), 64'd1);
        drain();

        // Partial byte write then full-word read back
        send(OP_PUTP, 2'd0, 4'd5, 32'h21, 4'h2, 32'h0000AB00, 5, ok, w);
        chk("putp_acc", 64'(ok), 64'd1);
        send(OP_GET, 2'd2, 4'd6, 32'h20, 4'hF, 32'h0, 5, ok, w);
        chk("get20_acc", 64'(ok), 64'd1);
        drain();

        // Back-to-back Get/Put/Get, one per cycle
        resp_cyc.delete();
        send(OP_GET, 2'd2, 4'd1, 32'h10, 4'hF, 32'h0, 1, ok, w);
        chk("b2b0_wait", 64'(w), 64'd0);
        send(OP_PUTF, 2'd2, 4'd2, 32'h14, 4'hF, 32'h12345678, 1, ok, w);
        chk("b2b1_wait", 64'(w), 64'd0);
        send(OP_GET, 2'd2, 4'd4, 32'h14, 4'hF, 32'h0, 1, ok, w);
        chk("b2b2_wait", 64'(w), 64'd0);
        drain();
        chk("b2b_cnt", 64'(resp_cyc.size()), 64'd3);
        if (resp_cyc.size() == 3) begin
            chk("b2b_gap0", 64'(resp_cyc[1] - resp_cyc[0]), 64'd1);
            chk("b2b_gap1", 64'(resp_cyc[2] - resp_cyc[1]), 64'd1);
        end

        // Backpressure: credits cap outstanding at 4
        d_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(OP_GET, 2'd2, 4'(8 + i), 32'(32'h40 + 4 * i), 4'hF, 32'h0, 2, ok, w);
            if (ok) acc++;
        end
        chk("bp_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        chk("bp_a_ready", 64'(a_ready), 64'd0);
        @(posedge clk); #1;
        n0 = nresp;
        d_ready = 1'b1;
        drain();
        chk("bp_drained", 64'(nresp - n0), 64'd4);
        send(OP_GET, 2'd2, 4'd12, 32'h50, 4'hF, 32'h0, 5, ok, w);
        chk("bp_resume0", 64'(ok), 64'd1);
        send(OP_GET, 2'd2, 4'd13, 32'h54, 4'hC, 32'h0, 5, ok, w);
        chk("bp_resume1", 64'(ok), 64'd1);
        drain();

        // Illegal requests: misaligned Get, short-mask PutFull
        send(OP_GET, 2'd2, 4'd9, 32'h12, 4'hF, 32'h0, 5, ok, w);
        chk("ill_get_acc", 64'(ok), 64'd1);
        send(OP_PUTF, 2'd2, 4'd10, 32'h30, 4'h7, 32'hFFFFFFFF, 5, ok, w);
        chk("ill_put_acc", 64'(ok), 64'd1);
        drain();
        chk("ill_ram_untouched", 64'(ram[12]), 64'(shadow[12]));

        // Reset with requests outstanding
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(OP_GET, 2'd2, 4'(i), 32'(32'h60 + 4 * i), 4'hF, 32'h0, 5, ok, w);
        end
        reset_i = 1'b1;
        #1;
        chk("mid_rst_d_valid", 64'(d_valid), 64'd0);
        chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
        chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_stale", 64'(d_valid), 64'd0);
        end
        @(posedge clk); #1;
        n0 = nresp;
        send(OP_GET, 2'd2, 4'd7, 32'h10, 4'hF, 32'h0, 5, ok, w);
        chk("post_rst_acc", 64'(ok), 64'd1);
        drain();
        chk("post_rst_rsp", 64'(nresp - n0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
